spike_window_classifier: RTL and testbench

//  Downstream consumer of the neuron array's per-neuron spike vector. Counts spikes over a

---
 rtl/spike_window_classifier_if.sv | 28 ++
 rtl/spike_window_classifier.sv | 142 ++++++++++++++
 tb/tb_spike_window_classifier.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/spike_window_classifier_if.sv
// Result channel of spike_window_classifier: valid/ready handshake plus the classification fields.
// master = classifier (producer), slave = downstream consumer.
interface spike_window_classifier_if #(
    parameter int unsigned NUM_NEURONS = 16,
    parameter int unsigned CNT_W       = 12
);
    logic                   result_valid;
    logic                   result_ready;
    logic [CNT_W-1:0]       result_count;
    logic                   result_detect;
    logic [NUM_NEURONS-1:0] active_mask;

    modport master (
        output result_valid,
        output result_count,
        output result_detect,
        output active_mask,
        input  result_ready
    );

    modport slave (
        input  result_valid,
        input  result_count,
        input  result_detect,
        input  active_mask,
        output result_ready
    );
endinterface

// File: rtl/spike_window_classifier.sv
// Windowed spike counter/classifier: counts spikes over WINDOW valid samples per frame and reports
// count, activity mask and detect flag over a valid/ready channel. Optional macro: SPIKE_HYST_EN.
module spike_window_classifier #(
    parameter int unsigned NUM_NEURONS = 16,
    parameter int unsigned WINDOW      = 64,
    parameter int unsigned CNT_W       = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    input  logic                   spike_valid,
    input  logic [NUM_NEURONS-1:0] spike_in,
    input  logic [CNT_W-1:0]       thresh,
    spike_window_classifier_if.master res,
    output logic                   busy,
    output logic                   overrun
);
    localparam int unsigned PC_W  = $clog2(NUM_NEURONS + 1);
    localparam int unsigned SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam int unsigned SMP_W = $clog2(WINDOW + 1);
    localparam logic [SMP_W-1:0] LastSample = SMP_W'(WINDOW);
    localparam logic [SUM_W-1:0] CntMax = {{(SUM_W - CNT_W){1'b0}}, {CNT_W{1'b1}}};

    typedef enum logic [1:0] {StIdle, StAccum, StReport} state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [NUM_NEURONS-1:0] mask_q, mask_d;
    logic [SMP_W-1:0]       samp_q, samp_d;
    logic [CNT_W-1:0]       thresh_q, thresh_d;
    logic [CNT_W-1:0]       res_count_q, res_count_d;
    logic                   res_detect_q, res_detect_d;
    logic [NUM_NEURONS-1:0] res_mask_q, res_mask_d;

    logic                   transfer, start, take, prev_eff;
    logic [PC_W-1:0]        pop;
    logic [SUM_W-1:0]       sum;
    logic [CNT_W-1:0]       base_count, acc_count, thr_eff;
    logic [NUM_NEURONS-1:0] base_mask, acc_mask;
    logic [SMP_W-1:0]       base_samp, acc_samp;

`ifdef SPIKE_HYST_EN
    logic prev_detect_q, prev_detect_d;
`endif

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        mask_d       = mask_q;
        samp_d       = samp_q;
        thresh_d     = thresh_q;
        res_count_d  = res_count_q;
        res_detect_d = res_detect_q;
        res_mask_d   = res_mask_q;

        pop = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            pop = pop + PC_W'(spike_in[i]);
        end

        transfer = (state_q == StReport) && res.result_ready;
        // frame_start is honoured everywhere except a REPORT that is still stalled
        start    = frame_start && ((state_q != StReport) || res.result_ready);
        overrun  = (state_q == StReport) && frame_start && !res.result_ready;
        take     = spike_valid && (start || (state_q == StAccum));

        base_count = start ? '0 : count_q;
        base_mask  = start ? '0 : mask_q;
        base_samp  = start ? '0 : samp_q;
        thr_eff    = start ? thresh : thresh_q;

        sum       = SUM_W'(base_count) + SUM_W'(pop);
        acc_count = (sum > CntMax) ? CntMax[CNT_W-1:0] : sum[CNT_W-1:0];
        acc_mask  = base_mask | spike_in;
        acc_samp  = base_samp + 1'b1;

`ifdef SPIKE_HYST_EN
        prev_detect_d = prev_detect_q;
        if (transfer) prev_detect_d = res_detect_q;
        prev_eff = transfer ? res_detect_q : prev_detect_q;
`else
        prev_eff = 1'b0;
`endif

        if (transfer) state_d = StIdle;

        if (start) begin
            state_d  = StAccum;
            count_d  = '0;
            mask_d   = '0;
            samp_d   = '0;
            thresh_d = thresh;
        end

        if (take) begin
            count_d = acc_count;
            mask_d  = acc_mask;
            samp_d  = acc_samp;
            if (acc_samp == LastSample) begin
                state_d      = StReport;
                res_count_d  = acc_count;
                res_mask_d   = acc_mask;
                res_detect_d = prev_eff ? (acc_count >= (thr_eff >> 1)) : (acc_count >= thr_eff);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            count_q      <= '0;
            mask_q       <= '0;
            samp_q       <= '0;
            thresh_q     <= '0;
            res_count_q  <= '0;
            res_detect_q <= 1'b0;
            res_mask_q   <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            mask_q       <= mask_d;
            samp_q       <= samp_d;
            thresh_q     <= thresh_d;
            res_count_q  <= res_count_d;
            res_detect_q <= res_detect_d;
            res_mask_q   <= res_mask_d;
        end
    end

`ifdef SPIKE_HYST_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) prev_detect_q <= 1'b0;
        else      prev_detect_q <= prev_detect_d;
    end
`endif

    assign res.result_valid  = (state_q == StReport);
    assign res.result_count  = res_count_q;
    assign res.result_detect = res_detect_q;
    assign res.active_mask   = res_mask_q;
    assign busy              = (state_q == StAccum);
endmodule

// File: tb/tb_spike_window_classifier.sv
// Bench for spike_window_classifier: two instances (CNT_W=12 and saturating CNT_W=4, WINDOW=4)
// share stimulus and are compared every cycle against a queue-based window model.
module tb_spike_window_classifier;
    localparam int N = 16;
    localparam int W = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_start = 1'b0;
    logic        spike_valid = 1'b0;
    logic [15:0] spike_in = '0;
    logic [11:0] thresh = '0;
    logic        busy_m, busy_s, ovr_m, ovr_s;

    int checks = 0;
    int failures = 0;

    spike_window_classifier_if #(.NUM_NEURONS(N), .CNT_W(12)) ifm ();
    spike_window_classifier_if #(.NUM_NEURONS(N), .CNT_W(4))  ifs ();

    spike_window_classifier #(.NUM_NEURONS(N), .WINDOW(W), .CNT_W(12)) dut_m (
        .clk(clk), .rst(rst), .frame_start(frame_start), .spike_valid(spike_valid),
        .spike_in(spike_in), .thresh(thresh), .res(ifm.master), .busy(busy_m), .overrun(ovr_m)
    );

    spike_window_classifier #(.NUM_NEURONS(N), .WINDOW(W), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .frame_start(frame_start), .spike_valid(spike_valid),
        .spike_in(spike_in), .thresh(thresh[3:0]), .res(ifs.master), .busy(busy_s),
        .overrun(ovr_s)
    );

    always #5 clk = ~clk;

    // Model: 0 idle, 1 collecting, 2 holding a result
    int          m_st = 0;
    int          m_q[$];
    logic [15:0] m_mask = '0, m_rmask = '0;
    int          m_thr = 0, m_rc = 0, m_rc4 = 0;
    logic        m_rd = 0, m_rd4 = 0, m_prev = 0, m_prev4 = 0;

    function automatic logic det(input int cnt, input int th, input logic prev);
`ifdef SPIKE_HYST_EN
        return prev ? (cnt >= (th >> 1)) : (cnt >= th);
`else
        return cnt >= th;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_q.delete(); m_mask = '0; m_rmask = '0; m_thr = 0;
        m_rc = 0; m_rc4 = 0; m_rd = 0; m_rd4 = 0; m_prev = 0; m_prev4 = 0;
    endtask

    task automatic model_step(input logic fs, input logic sv, input logic [15:0] si,
                              input logic rdy, input logic [11:0] thr);
        int total;
        bit xfer = (m_st == 2) && rdy;
        bit strt = fs && ((m_st != 2) || rdy);
        if (xfer) begin m_prev = m_rd; m_prev4 = m_rd4; m_st = 0; end
        if (strt) begin m_q.delete(); m_mask = '0; m_thr = int'(thr); m_st = 1; end
        if (sv && m_st == 1) begin
            m_q.push_back($countones(si));
            m_mask |= si;
            if (m_q.size() == W) begin
                total = 0;
                foreach (m_q[k]) total += m_q[k];
                m_rc    = (total > 4095) ? 4095 : total;
                m_rc4   = (total > 15) ? 15 : total;
                m_rd    = det(m_rc, m_thr, m_prev);
                m_rd4   = det(m_rc4, m_thr & 15, m_prev4);
                m_rmask = m_mask;
                m_st    = 2;
            end
        end
    endtask

    task automatic check_outputs();
        check("valid_m", 32'(ifm.result_valid), 32'(m_st == 2));
        check("busy_m", 32'(busy_m), 32'(m_st == 1));
        check("count_m", 32'(ifm.result_count), 32'(m_rc));
        check("detect_m", 32'(ifm.result_detect), 32'(m_rd));
        check("mask_m", 32'(ifm.active_mask), 32'(m_rmask));
        check("valid_s", 32'(ifs.result_valid), 32'(m_st == 2));
        check("busy_s", 32'(busy_s), 32'(m_st == 1));
        check("count_s", 32'(ifs.result_count), 32'(m_rc4));
        check("detect_s", 32'(ifs.result_detect), 32'(m_rd4));
        check("mask_s", 32'(ifs.active_mask), 32'(m_rmask));
    endtask

    // Called at a falling edge; returns at the next falling edge with outputs checked.
    task automatic step(input logic fs, input logic sv, input logic [15:0] si,
                        input logic rdy, input logic [11:0] thr);
        logic exp_ovr;
        frame_start = fs; spike_valid = sv; spike_in = si; thresh = thr;
        ifm.result_ready = rdy; ifs.result_ready = rdy;
        #1;
        exp_ovr = (m_st == 2) && fs && !rdy;
        check("overrun_m", 32'(ovr_m), 32'(exp_ovr));
        check("overrun_s", 32'(ovr_s), 32'(exp_ovr));
        model_step(fs, sv, si, rdy, thr);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        ifm.result_ready = 1'b0;
        ifs.result_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        rst = 1'b1;
        @(negedge clk);

        // Basic window: 2 spikes x 4 samples against threshold 5
        step(1, 1, 16'h0003, 0, 12'd5);
        for (int i = 0; i < 3; i++) step(0, 1, 16'h0003, 0, 12'd5);
        check("t2_count", 32'(ifm.result_count), 32'd8);
        check("t2_detect", 32'(ifm.result_detect), 32'd1);
        check("t2_mask", 32'(ifm.active_mask), 32'h0003);

        // Backpressure with a dropped frame_start, then release
        for (int i = 0; i < 10; i++) step((i == 4), 1, 16'hFFFF, 0, 12'd1);
        check("t3_count_held", 32'(ifm.result_count), 32'd8);
        step(0, 0, 16'h0, 1, 12'd0);
        check("t3_idle", 32'(ifm.result_valid), 32'd0);

        // Abort at sample 2, then restart with a coincident sample
        step(1, 1, 16'h00F0, 0, 12'd3);
        step(1, 1, 16'h0101, 0, 12'd6);
        step(0, 0, 16'hFFFF, 0, 12'd6);
        for (int i = 0; i < 3; i++) step(0, 1, 16'h0100, 0, 12'd6);
        check("t4_count", 32'(ifm.result_count), 32'd5);
        step(1, 0, 16'h0, 1, 12'd2);
        check("t4_busy", 32'(busy_m), 32'd1);
        for (int i = 0; i < 4; i++) step(0, 1, 16'h8000, 0, 12'd2);
        step(0, 0, 16'h0, 1, 12'd0);

        // Saturation on the narrow instance, threshold 0
        step(1, 1, 16'hFFFF, 0, 12'd0);
        for (int i = 0; i < 3; i++) step(0, 1, 16'hFFFF, 0, 12'd0);
        check("t5_sat", 32'(ifs.result_count), 32'd15);
        check("t5_detect", 32'(ifs.result_detect), 32'd1);
        step(0, 0, 16'h0, 1, 12'd0);

        // Asynchronous reset in the middle of a window
        step(1, 1, 16'h0F0F, 0, 12'd1);
        step(0, 1, 16'h0F0F, 0, 12'd1);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 1, 16'hFFFF, 1, 12'd0);

        // Three windows at threshold 8 with counts 8, 5, 3
        step(1, 1, 16'h0003, 0, 12'd8);
        for (int i = 0; i < 3; i++) step(0, 1, 16'h0003, 0, 12'd8);
        step(0, 0, 16'h0, 1, 12'd8);
        step(1, 1, 16'h0003, 0, 12'd8);
        for (int i = 0; i < 3; i++) step(0, 1, 16'h0001, 0, 12'd8);
        step(0, 0, 16'h0, 1, 12'd8);
        step(1, 1, 16'h0001, 0, 12'd8);
        step(0, 1, 16'h0001, 0, 12'd8);
        step(0, 1, 16'h0001, 0, 12'd8);
        step(0, 1, 16'h0000, 0, 12'd8);
        check("t6_count", 32'(ifm.result_count), 32'd3);
        step(0, 0, 16'h0, 1, 12'd8);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
                 16'($urandom), ($urandom_range(0, 2) != 0), 12'($urandom_range(0, 40)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
